// File: rtl/mac_mul_block_pipe.sv
// ----------------------------------------------------------------------------
// mac_mul_block_pipe
//
// Pipelined per-column MAC multiply block. One shared B operand is multiplied
// against LANES unsigned A lanes. The lane products are then combined according
// to cfg (single / dual / quad). The result is delivered through a
// PIPE_STAGES-deep valid/ready pipeline to the accumulator stage.
//
// Pipeline shape:
//   stage 1 .. PIPE_STAGES-1 : lane products + cfg + valid (stage 1 computes the products)
//   final stage (C)          : combined result + out_valid
// With PIPE_STAGES == 1 the products and the combine are both evaluated from the
// input, and the result is registered straight into C.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   en         pipeline enable; 0 freezes every register
//   cfg        `MAC_SINGLE / `MAC_DUAL / `MAC_QUAD; 2'b11 reserved (result 0)
//   A          LANES lanes, lane i at A[i*W +: W], unsigned
//   B          shared multiplicand, unsigned
//   in_valid   input beat present
//   in_ready   beat accepted this cycle (combinational)
//   C          combined product, registered, (LANES+1)*W bits
//   out_valid  C holds a valid result
//   out_ready  downstream takes C this cycle
//   op_count   saturating count of completed output transfers
//              (present only when MAC_MUL_CNT_EN is defined)
//
// Build option:
//   MAC_MUL_CNT_EN  adds the op_count port and its counter. When the macro is
//                   not defined, the datapath and the handshake are unchanged.
//
// Parameters: LANES must be >= 2. PIPE_STAGES must be in the range 1..4.
// ----------------------------------------------------------------------------

`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module mac_mul_block_pipe #(
    parameter int unsigned MIN_WIDTH   = `MAC_MIN_WIDTH,
    parameter int unsigned LANES       = 4,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [1:0]                       cfg,
    input  logic [LANES*MIN_WIDTH-1:0]       A,
    input  logic [MIN_WIDTH-1:0]             B,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [(LANES+1)*MIN_WIDTH-1:0]   C,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef MAC_MUL_CNT_EN
    ,
    output logic [15:0]                      op_count
`endif
);

    localparam int unsigned W      = MIN_WIDTH;
    localparam int unsigned PW     = 2 * MIN_WIDTH;
    localparam int unsigned CW     = (LANES + 1) * MIN_WIDTH;
    localparam int unsigned NumMid = PIPE_STAGES - 1;

    // ------------------------------------------------------------------------
    // Handshake: the whole pipe moves as one unit, so a single advance term
    // gates every register.
    // ------------------------------------------------------------------------
    logic adv;
    logic out_valid_q, out_valid_d;
    logic [CW-1:0] c_q, c_d;

    assign adv       = en & (~out_valid_q | out_ready);
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign C         = c_q;

    // ------------------------------------------------------------------------
    // Lane products (stage-1 logic)
    // ------------------------------------------------------------------------
    logic [PW-1:0] prod_in [LANES];

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_in[i] = PW'(A[i*W +: W]) * PW'(B);
        end
    end

    // Signals that feed the combine in the final stage.
    logic [PW-1:0] fin_prod [LANES];
    logic [1:0]    fin_cfg;
    logic          fin_vld;

    if (NumMid == 0) begin : g_direct
        // Single stage: the combine sees the products of the current input.
        always_comb begin
            fin_prod = prod_in;
            fin_cfg  = cfg;
            fin_vld  = in_valid;
        end
    end else begin : g_stages
        logic [PW-1:0] mid_prod_q [NumMid][LANES];
        logic [PW-1:0] mid_prod_d [NumMid][LANES];
        logic [1:0]    mid_cfg_q  [NumMid];
        logic [1:0]    mid_cfg_d  [NumMid];
        logic          mid_vld_q  [NumMid];
        logic          mid_vld_d  [NumMid];

        always_comb begin
            mid_prod_d = mid_prod_q;
            mid_cfg_d  = mid_cfg_q;
            mid_vld_d  = mid_vld_q;
            if (adv) begin
                // cfg is captured with its beat, so later cfg changes affect
                // only later beats.
                mid_prod_d[0] = prod_in;
                mid_cfg_d[0]  = cfg;
                mid_vld_d[0]  = in_valid;
                for (int unsigned s = 1; s < NumMid; s++) begin
                    mid_prod_d[s] = mid_prod_q[s-1];
                    mid_cfg_d[s]  = mid_cfg_q[s-1];
                    mid_vld_d[s]  = mid_vld_q[s-1];
                end
            end
        end

        // Only the valid bits need a reset. Data behind a bubble is never used.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int unsigned s = 0; s < NumMid; s++) begin
                    mid_vld_q[s] <= 1'b0;
                end
            end else begin
                mid_vld_q <= mid_vld_d;
            end
        end

        always_ff @(posedge clk) begin
            mid_prod_q <= mid_prod_d;
            mid_cfg_q  <= mid_cfg_d;
        end

        always_comb begin
            fin_prod = mid_prod_q[NumMid-1];
            fin_cfg  = mid_cfg_q[NumMid-1];
            fin_vld  = mid_vld_q[NumMid-1];
        end
    end

    // ------------------------------------------------------------------------
    // Combine (final stage). The (LANES+1)*W width holds the largest quad sum,
    // so no carry is ever dropped.
    // ------------------------------------------------------------------------
    logic [CW-1:0] comb_c;

    always_comb begin
        comb_c = '0;
        case (fin_cfg)
            `MAC_SINGLE: comb_c = CW'(fin_prod[LANES-1]);
            `MAC_DUAL:   comb_c = CW'(fin_prod[LANES-2]) + (CW'(fin_prod[LANES-1]) << W);
            `MAC_QUAD: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    comb_c = comb_c + (CW'(fin_prod[i]) << (i * W));
                end
            end
            default:     comb_c = '0;  // reserved cfg: the beat still completes, with value 0
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        if (adv) begin
            out_valid_d = fin_vld;
            // A bubble leaves the last result in C. Only out_valid drops.
            if (fin_vld) begin
                c_d = comb_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional completed-operation counter
    // ------------------------------------------------------------------------
`ifdef MAC_MUL_CNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        // A transfer only happens while enabled. en=0 freezes the count even
        // when out_valid and out_ready are both high.
        if (en && out_valid_q && out_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_count_q <= 16'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mac_mul_block_pipe.sv
// ----------------------------------------------------------------------------
// tb_mac_mul_block_pipe
//
// Self-checking bench for mac_mul_block_pipe (W=8, LANES=4, PIPE_STAGES=2).
// It uses table-driven directed vectors, plus hand-written sequences for
// latency, backpressure, enable hold, reset mid-operation and, when
// MAC_MUL_CNT_EN is defined, the operation counter.
// ----------------------------------------------------------------------------

module tb_mac_mul_block_pipe;

    localparam logic [1:0] CfgSingle = 2'b00;
    localparam logic [1:0] CfgDual   = 2'b01;
    localparam logic [1:0] CfgQuad   = 2'b10;
    localparam logic [1:0] CfgRsvd   = 2'b11;
    localparam int         NumVecs   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  cfg;
    logic [31:0] A;
    logic [7:0]  B;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] C;
    logic        out_valid;
    logic        out_ready;
`ifdef MAC_MUL_CNT_EN
    logic [15:0] op_count;
`endif

    always #5 clk = ~clk;

    mac_mul_block_pipe #(
        .MIN_WIDTH   (8),
        .LANES       (4),
        .PIPE_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MAC_MUL_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    typedef struct {
        logic [1:0]  cfg;
        logic [31:0] a;
        logic [7:0]  b;
        logic [39:0] exp_c;
    } vec_t;

    vec_t        vecs [NumVecs];
    logic [39:0] exp_q [$];
    logic [39:0] cur_exp;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        cfg     = v.cfg;
        A       = v.a;
        B       = v.b;
        cur_exp = v.exp_c;
    endtask

    // Called at a negedge once this cycle's inputs are set. A handshake seen
    // now takes effect at the coming posedge.
    task automatic tick(input string tag, output bit acc);
        #1;
        if (out_valid && out_ready && en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s spurious beat: got C=%0h, required no beat", tag, C);
            end else begin
                check({tag, " C"}, 64'(C), 64'(exp_q.pop_front()));
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(cur_exp);
        @(negedge clk);
    endtask

    // Sends vecs[first +: count] back to back. out_ready is held low for the
    // first stall_cycles cycles. The task returns after the pipe has drained.
    task automatic stream(input int first, input int count, input int stall_cycles,
                          input string tag, output int stalls);
        int idx;
        int cyc;
        bit acc;
        idx    = first;
        cyc    = 0;
        stalls = 0;
        while (((idx < first + count) || (exp_q.size() != 0)) && (cyc < 60)) begin
            out_ready = (cyc >= stall_cycles);
            if (idx < first + count) begin
                in_valid = 1'b1;
                apply(vecs[idx]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check({tag, " in_ready in stall"}, 64'(in_ready), 64'd0);
                if (exp_q.size() != 0) check({tag, " C held in stall"}, 64'(C), 64'(exp_q[0]));
            end
            tick(tag, acc);
            if (acc) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drain(input string tag);
        bit acc;
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0) && (n < 10)) begin
            tick(tag, acc);
            n++;
        end
        check({tag, " drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int stalls;
        bit acc;
        vecs[0] = '{CfgSingle, 32'h12000000, 8'h10, 40'h0000000120};
        vecs[1] = '{CfgQuad,   32'h04030201, 8'h02, 40'h0008060402};
        vecs[2] = '{CfgDual,   32'h04030201, 8'h02, 40'h0000000806};
        vecs[3] = '{CfgRsvd,   32'hFFFFFFFF, 8'hFF, 40'h0000000000};
        vecs[4] = '{CfgQuad,   32'hFFFFFFFF, 8'hFF, 40'hFEFFFFFF01};
        vecs[5] = '{CfgDual,   32'hFFFFFFFF, 8'hFF, 40'h0000FEFF01};
        vecs[6] = '{CfgSingle, 32'hFFFFFFFF, 8'hFF, 40'h000000FE01};
        vecs[7] = '{CfgQuad,   32'h80000001, 8'h80, 40'h4000000080};
        vecs[8] = '{CfgQuad,   32'h12345678, 8'h00, 40'h0000000000};
        vecs[9] = '{CfgDual,   32'h01ABCDEF, 8'h03, 40'h0000000501};

        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg       = CfgSingle;
        A         = '0;
        B         = '0;
        cur_exp   = '0;

        // Reset state
        @(negedge clk);
        do_reset();
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset C", 64'(C), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Single-beat latency: accepted at edge N, valid after edge N+1
        apply(vecs[0]);
        in_valid = 1'b1;
        #1;
        check("lat in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat out_valid after N", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat out_valid after N+1", 64'(out_valid), 64'd1);
        check("lat C single", 64'(C), 64'h120);
        @(negedge clk);
        check("lat out_valid after consume", 64'(out_valid), 64'd0);

        // Full table, back to back, without stalls
        stream(0, NumVecs, 0, "table", stalls);
        check("table stalls", 64'(stalls), 64'd0);

        // Backpressure: 3 beats, out_ready low for 5 cycles once the output is valid
        stream(1, 3, 7, "bp", stalls);
        check("bp stall cycles", 64'(stalls), 64'd5);

        // en=0 holds everything
        out_ready = 1'b0;
        in_valid  = 1'b1;
        apply(vecs[4]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        en        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("en0 in_ready", 64'(in_ready), 64'd0);
            check("en0 out_valid", 64'(out_valid), 64'd1);
            check("en0 C", 64'(C), 64'(vecs[4].exp_c));
            @(negedge clk);
        end
        en = 1'b1;
        exp_q.push_back(vecs[4].exp_c);
        drain("en0 drain");

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        apply(vecs[7]);
        @(negedge clk);
        apply(vecs[9]);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst C", 64'(C), 64'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            tick("midrst stale", acc);
            check("midrst no stale beat", 64'(out_valid), 64'd0);
        end

`ifdef MAC_MUL_CNT_EN
        do_reset();
        check("cnt reset", 64'(op_count), 64'd0);
        stream(0, NumVecs, 0, "cnt10", stalls);
        check("cnt after 10", 64'(op_count), 64'd10);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        apply(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        en        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cnt en0 in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("cnt en0 hold", 64'(op_count), 64'd10);
        end
        en = 1'b1;
        exp_q.push_back(vecs[1].exp_c);
        drain("cnt en0 drain");
        check("cnt after 11", 64'(op_count), 64'd11);
        dut.op_count_q = 16'hFFFE;
        stream(0, 3, 0, "cntsat", stalls);
        check("cnt saturate", 64'(op_count), 64'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
